div_iter_rv: RTL and testbench
==============================

Name: div_iter_rv

Overview:
- Parametrised iterative radix-2 restoring divider for the M-extension execute stage; replaces the fixed 32-bit unsigned divider.
- Supports signed and unsigned operands, with RISC-V-exact corner-case results (divide-by-zero and signed overflow).
- Uses a valid/ready handshake on both input and output, so the pipeline can stall the result.
- One operation in flight; the caller selects quotient or remainder downstream.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range is 4 or more.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-high; has priority over all other inputs.
- in_valid  input  1  operands and op_signed are valid this cycle.
- in_ready  output  1  divider can accept an operation.
- op_signed  input  1  1 selects DIV/REM (two's complement); 0 selects DIVU/REMU.
- nume  input  WIDTH  dividend.
- den  input  WIDTH  divisor.
- out_valid  output  1  quotient and remainder are valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- busy  output  1  high while an operation is accepted and not yet retired.

Behaviour:
- Reset (clr=1 at an edge) gives: state=IDLE, in_ready=1, out_valid=0, busy=0, quotient=0, remainder=0, counter=0.
- clr in any state, including mid-CALC, abandons the operation. No out_valid is ever produced for it. in_ready=1 in the following cycle.
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE).
- Accept occurs when in_valid & in_ready at an edge (call this cycle T). At that edge:
  - latch sign_q = op_signed & (nume[MSB]^den[MSB]);
  - latch sign_r = op_signed & nume[MSB];
  - latch magnitudes |nume| and |den|; absolute value applies only when op_signed, using unsigned WIDTH-bit negation, so that -2^(W-1) maps to 2^(W-1);
  - latch the raw nume, a den_zero flag, and counter=0;
  - go to CALC.
- In CALC, each cycle performs one restoring step:
  - partial remainder (WIDTH+1 bits) is shifted left with the next dividend MSB;
  - subtract |den| if the result is non-negative and set the quotient bit to 1; otherwise restore and set the bit to 0;
  - counter += 1; after WIDTH steps go to FIX.
- FIX, one cycle:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r, both truncated to WIDTH;
  - if den_zero, force quotient to all-ones and remainder to raw nume, regardless of op_signed;
  - go to DONE.
- Signed overflow (nume = -2^(W-1), den = -1, op_signed=1) falls out naturally from the datapath: quotient = nume, remainder = 0. No special logic.
- Division truncates toward zero. The remainder takes the sign of the dividend. For all non-zero divisors: nume == quotient*den + remainder (mod 2^WIDTH).
- DONE:
  - out_valid=1; quotient and remainder are held stable until out_ready=1;
  - on the edge with out_ready=1, go to IDLE; out_valid falls in the next cycle;
  - out_ready with out_valid=0 has no effect.
- Latency without fast path: out_valid first high in cycle T+WIDTH+2. Throughput is one operation per WIDTH+3 cycles at minimum.
- in_valid while in_ready=0 is ignored; operands are not sampled.
- Outputs change only on FIX→DONE and on clr.

Optional Feature:
- Macro DIV_FASTPATH_EN.
- When defined, the accept edge checks for three cases: den==0, |den|==1, or |nume| < |den| (unsigned magnitude compare).
  - On a hit, the raw quotient/remainder are loaded directly (q=all-ones/r=|nume|; q=|nume|/r=0; q=0/r=|nume| respectively).
  - The divider then skips CALC and goes straight to FIX. Sign fix and den_zero override apply unchanged.
  - out_valid is high at T+2.
- When undefined, every operation takes the full T+WIDTH+2 path. Results are bit-identical in both builds.

Test Plan (WIDTH=32):
1. Unsigned 100/7: accept at T -> q=14, r=2, out_valid at T+34 (T+34 also with the macro).
2. Signed sign cases:
   - -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF;
   - 7/-2 -> q=0xFFFFFFFD, r=1;
   - -7/-2 -> q=3, r=0xFFFFFFFF.
3. Divide by zero: 0x12345678/0, signed and unsigned -> q=0xFFFFFFFF, r=0x12345678.
4. Overflow:
   - signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0;
   - unsigned, same operands -> q=0, r=0x80000000.
5. Backpressure and clr:
   - hold out_ready=0 for 5 cycles in DONE; q/r stay stable and in_valid pulses are ignored;
   - separately, assert clr at T+10 of 1000/3; in_ready=1 at T+11, no out_valid;
   - then 9/3 -> q=3, r=0.
6. Fast path (DIV_FASTPATH_EN): unsigned 5/16 -> q=0, r=5 at T+2; signed 0x80000000/0xFFFFFFFF -> out_valid at T+2 with the case-4 values.

Source files
------------

// File: rtl/div_iter_rv.sv
// div_iter_rv: iterative radix-2 restoring divider with valid/ready on both sides.
// Handles signed (DIV/REM) and unsigned (DIVU/REMU) operands with RISC-V
// divide-by-zero and signed-overflow results.
// Optional build macro DIV_FASTPATH_EN: trivial operations (den==0, |den|==1,
// |nume|<|den|) skip the iteration and go straight to the sign-fix cycle.
//
// Handshake: an operation is accepted on a rising edge where in_valid & in_ready;
// a result is retired on a rising edge where out_valid & out_ready. in_ready is
// high only in IDLE, and out_valid is high only in DONE, with quotient/remainder
// held stable until retired.
module div_iter_rv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] nume,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r, den_zero;
  logic [WIDTH-1:0] nume_raw, den_abs;
  logic [WIDTH-1:0] quo_w;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_w;      // partial remainder, always < |den| between steps
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             accept, last_step, fast_hit;
  logic [WIDTH-1:0] nume_abs, den_abs_in;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  // Operand magnitudes; unsigned negation maps -2^(W-1) onto 2^(W-1).
  always_comb begin
    nume_abs   = (op_signed && nume[WIDTH-1]) ? -nume : nume;
    den_abs_in = (op_signed && den[WIDTH-1])  ? -den  : den;
  end

`ifdef DIV_FASTPATH_EN
  logic [WIDTH-1:0] fast_q, fast_r;

  // Trivial cases resolved at accept time with raw (unsigned) results.
  always_comb begin
    fast_hit = 1'b1;
    fast_q   = '0;
    fast_r   = nume_abs;
    if (den == '0) begin
      fast_q = '1;
    end else if (den_abs_in == {{(WIDTH-1){1'b0}}, 1'b1}) begin
      fast_q = nume_abs;
      fast_r = '0;
    end else if (nume_abs < den_abs_in) begin
      fast_q = '0;
    end else begin
      fast_hit = 1'b0;
    end
  end
`else
  assign fast_hit = 1'b0;
`endif

  // One restoring step and the final sign/zero-divisor correction.
  always_comb begin
    shifted = {rem_w, quo_w[WIDTH-1]};
    diff    = shifted - {1'b0, den_abs};
    q_fix   = sign_q ? -quo_w : quo_w;
    r_fix   = sign_r ? -rem_w : rem_w;
    if (den_zero) begin
      q_fix = '1;
      r_fix = nume_raw;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)    state_nx = fast_hit ? FIX : CALC;
      CALC: if (last_step) state_nx = FIX;
      FIX:                 state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // State register; clr abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath: latch operands on accept, iterate in CALC, publish results in FIX.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      den_zero    <= 1'b0;
      nume_raw    <= '0;
      den_abs     <= '0;
      quo_w       <= '0;
      rem_w       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_q   <= op_signed & (nume[WIDTH-1] ^ den[WIDTH-1]);
          sign_r   <= op_signed & nume[WIDTH-1];
          nume_raw <= nume;
          den_abs  <= den_abs_in;
          den_zero <= (den == '0);
          cnt      <= '0;
`ifdef DIV_FASTPATH_EN
          if (fast_hit) begin
            quo_w <= fast_q;
            rem_w <= fast_r;
          end else begin
            quo_w <= nume_abs;
            rem_w <= '0;
          end
`else
          quo_w <= nume_abs;
          rem_w <= '0;
`endif
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (!diff[WIDTH]) begin
            rem_w <= diff[WIDTH-1:0];
            quo_w <= {quo_w[WIDTH-2:0], 1'b1};
          end else begin
            rem_w <= shifted[WIDTH-1:0];
            quo_w <= {quo_w[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_rv.sv
// tb_div_iter_rv: self-checking bench for div_iter_rv (WIDTH=32), directed
// corner cases plus randomized operations against an arithmetic reference.
module tb_div_iter_rv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr, in_valid, in_ready, op_signed;
  logic         out_valid, out_ready, busy;
  logic [W-1:0] nume, den, quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  div_iter_rv #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .op_signed(op_signed), .nume(nume), .den(den), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with RISC-V zero-divisor rule.
  function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Cycles from accept (T) to first out_valid.
  function automatic int ref_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ma, mb;
    ma = s ? longint'($signed(a)) : longint'(a);
    mb = s ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_FASTPATH_EN
    if (mb == 0 || mb == 1 || ma < mb) return 2;
`endif
    return W + 2;
  endfunction

  // Drive one operation, wait for result, hold it for `hold` cycles, retire it.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input string tag);
    logic [2*W-1:0] e;
    logic [W-1:0]   q0, r0;
    int lat, exp_lat;
    @(negedge clk);
    op_signed = s; nume = a; den = b; in_valid = 1'b1;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    exp_q.push_back(ref_div(s, a, b));
    exp_lat = ref_lat(s, a, b);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      op_signed = 1'($urandom_range(0, 1));
      nume = $urandom; den = $urandom;
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    q0 = quotient; r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      nume = $urandom; den = $urandom;
      @(negedge clk);
    end
    if (hold > 0) begin
      check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "/hold_stable"}, {quotient, remainder}, {q0, r0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    e = exp_q.pop_front();
    check({tag, "/quotient"}, 64'(quotient), 64'(e[2*W-1:W]));
    check({tag, "/remainder"}, 64'(remainder), 64'(e[W-1:0]));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/retired"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int lat, seen_valid;
    clr = 1'b1; in_valid = 1'b0; op_signed = 1'b0; out_ready = 1'b0;
    nume = '0; den = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/ctrl", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("reset/qr", {quotient, remainder}, 64'd0);
    clr = 1'b0;

    do_op(1'b0, 32'd100, 32'd7, 0, "udiv_100_7");
    do_op(1'b1, -32'sd7, 32'd2, 0, "sdiv_m7_2");
    do_op(1'b1, 32'd7, -32'sd2, 1, "sdiv_7_m2");
    do_op(1'b1, -32'sd7, -32'sd2, 0, "sdiv_m7_m2");
    do_op(1'b1, 32'h12345678, 32'd0, 0, "sdiv_by_zero");
    do_op(1'b0, 32'h12345678, 32'd0, 2, "udiv_by_zero");
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "sdiv_overflow");
    do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 0, "udiv_ovf_ops");
    do_op(1'b0, 32'd5, 32'd16, 0, "udiv_5_16");
    do_op(1'b1, 32'h0ABCDEF0, 32'h00000013, 5, "backpressure");

    // clr in the middle of CALC abandons the operation
    @(negedge clk);
    op_signed = 1'b0; nume = 32'd1000; den = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("clr/busy_before", 64'(busy), 64'd1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check("clr/after", {61'd0, in_ready, out_valid, busy}, 64'b100);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("clr/no_out_valid", 64'(seen_valid), 64'd0);
    do_op(1'b0, 32'd9, 32'd3, 0, "after_clr_9_3");

    // randomized mix with corner-biased operands
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 6))
        0: b = '0;
        1: b = '1;
        2: b = 32'd1;
        3: a = 32'h80000000;
        4: b = W'($urandom_range(1, 300));
        5: a = W'($urandom_range(0, 50));
        default: ;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
